div_sequencer: RTL and testbench

DIV_SEQUENCER -- requirements
Module: div_sequencer

---
 rtl/div_sequencer.sv | 153 +++++++++++++++
 tb/tb_div_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// Sequencer between the pipeline's M-extension divide ops and a multi-cycle divider.
// It resolves divide-by-zero, signed overflow and repeated operands locally; everything else goes to the divider.
module div_sequencer #(
    parameter int CACHE_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        flush,
    output logic        stall,
    output logic [31:0] result,
    output logic        result_valid,
    output logic        dv_start,
    output logic        dv_sign,
    output logic [31:0] dv_numerator,
    output logic [31:0] dv_denominator,
    input  logic [31:0] dv_quotient,
    input  logic [31:0] dv_remainder,
    input  logic        dv_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_RESP  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      state, state_next;

    logic        rem_sel;
    logic [31:0] quo_q, rem_q;
    logic [31:0] num_q, den_q;
    logic        sign_q;

    logic        c_valid, c_sign;
    logic [31:0] c_num, c_den, c_quo, c_rem;

    logic        div_req, req_sign, is_zero, is_ovf, hit;
    logic        accept, launch, capture, cache_clr;

    assign div_req  = req_valid & funct3[2];
    assign req_sign = ~funct3[0];
    assign is_zero  = (rs2 == 32'd0);
    assign is_ovf   = req_sign & (rs1 == 32'h8000_0000) & (rs2 == 32'hFFFF_FFFF);
    assign hit      = (CACHE_EN != 0) & c_valid & (rs1 == c_num) & (rs2 == c_den)
                      & (req_sign == c_sign);

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        launch     = 1'b0;
        capture    = 1'b0;
        cache_clr  = 1'b0;
        case (state)
            S_IDLE: begin
                if (div_req && !flush) begin
                    accept = 1'b1;
                    if (is_zero || is_ovf || hit) begin
                        state_next = S_RESP;
                    end else begin
                        launch     = 1'b1;
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // A kill arriving together with dv_done wins: the answer is dropped.
                if (flush) begin
                    cache_clr  = 1'b1;
                    state_next = S_DRAIN;
                end else if (dv_done) begin
                    capture    = 1'b1;
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            S_DRAIN: begin
                cache_clr = flush;
                if (dv_done) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            rem_sel <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            num_q   <= '0;
            den_q   <= '0;
            sign_q  <= 1'b0;
            c_valid <= 1'b0;
            c_sign  <= 1'b0;
            c_num   <= '0;
            c_den   <= '0;
            c_quo   <= '0;
            c_rem   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                rem_sel <= funct3[1];
                if (is_zero) begin
                    quo_q <= 32'hFFFF_FFFF;
                    rem_q <= rs1;
                end else if (is_ovf) begin
                    quo_q <= 32'h8000_0000;
                    rem_q <= '0;
                end else if (hit) begin
                    quo_q <= c_quo;
                    rem_q <= c_rem;
                end
            end
            if (launch) begin
                num_q  <= rs1;
                den_q  <= rs2;
                sign_q <= req_sign;
            end
            if (capture) begin
                quo_q   <= dv_quotient;
                rem_q   <= dv_remainder;
                c_valid <= 1'b1;
                c_num   <= num_q;
                c_den   <= den_q;
                c_sign  <= sign_q;
                c_quo   <= dv_quotient;
                c_rem   <= dv_remainder;
            end else if (cache_clr) begin
                c_valid <= 1'b0;
            end
        end
    end

    // Operands go straight through on the start cycle, then the registered copy holds them until dv_done.
    assign dv_start       = launch & ~rst;
    assign dv_numerator   = launch ? rs1 : num_q;
    assign dv_denominator = launch ? rs2 : den_q;
    assign dv_sign        = launch ? req_sign : sign_q;

    assign result_valid = (state == S_RESP) & ~flush;
    assign result       = result_valid ? (rem_sel ? rem_q : quo_q) : 32'd0;
    assign stall        = div_req & ~result_valid & ~flush & (state != S_DRAIN);

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed vector table, multi-cycle corner sequences,
// and randomized ops checked against a result/cache reference model.
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] rs1 = '0, rs2 = '0;
    logic        flush = 1'b0;
    logic        stall, result_valid, dv_start, dv_sign;
    logic [31:0] result, dv_numerator, dv_denominator;
    logic [31:0] dv_quotient = '0, dv_remainder = '0;
    logic        dv_done = 1'b0;

    int n_pass = 0, n_total = 0;
    int n_start = 0, n_rv = 0, n_done = 0;
    int div_lat = 3;
    int dv_cnt = 0;
    logic [31:0] pend_q, pend_r;

    // Reference cache: what a correct sequencer should remember.
    logic        m_valid = 1'b0, m_sign = 1'b0;
    logic [31:0] m_a = '0, m_b = '0;

    div_sequencer #(.CACHE_EN(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .flush(flush), .stall(stall),
        .result(result), .result_valid(result_valid),
        .dv_start(dv_start), .dv_sign(dv_sign),
        .dv_numerator(dv_numerator), .dv_denominator(dv_denominator),
        .dv_quotient(dv_quotient), .dv_remainder(dv_remainder), .dv_done(dv_done)
    );

    always #5 clk = ~clk;

    // Divider stub with programmable latency, plus event counters.
    always @(negedge clk) begin
        dv_done = 1'b0;
        if (dv_cnt > 0) begin
            dv_cnt--;
            if (dv_cnt == 0) begin
                dv_done      = 1'b1;
                dv_quotient  = pend_q;
                dv_remainder = pend_r;
                n_done++;
            end
        end
        if (dv_start) begin
            n_start++;
            dv_cnt = div_lat;
            if (dv_sign) begin
                pend_q = $signed(dv_numerator) / $signed(dv_denominator);
                pend_r = $signed(dv_numerator) % $signed(dv_denominator);
            end else begin
                pend_q = dv_numerator / dv_denominator;
                pend_r = dv_numerator % dv_denominator;
            end
        end
        if (result_valid) n_rv++;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        logic sg;
        sg = ~f3[0];
        if (b == 0) begin
            q = 32'hFFFF_FFFF; r = a;
        end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 0;
        end else if (sg) begin
            q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
        end else begin
            q = a / b; r = a % b;
        end
        return f3[1] ? r : q;
    endfunction

    // Returns whether the op should reach the divider, and updates the reference cache.
    function automatic logic ref_start(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic sg;
        sg = ~f3[0];
        if (b == 0 || (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1'b0;
        if (m_valid && m_a == a && m_b == b && m_sign == sg) return 1'b0;
        m_valid = 1'b1; m_a = a; m_b = b; m_sign = sg;
        return 1'b1;
    endfunction

    task automatic do_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input logic exp_start);
        int st0, rv0, cyc, lat;
        logic got, stall_ok;
        logic [31:0] res;
        st0 = n_start; rv0 = n_rv; cyc = 0; lat = -1; got = 1'b0; stall_ok = 1'b1; res = '0;
        req_valid = 1'b1; funct3 = f3; rs1 = a; rs2 = b;
        while (!got && cyc < 100) begin
            @(negedge clk);
            if (result_valid) begin
                got = 1'b1; res = result; lat = cyc;
                if (stall) stall_ok = 1'b0;
            end else if (!stall) begin
                stall_ok = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        req_valid = 1'b0;
        check({nm, "_valid"}, 32'(got), 32'd1);
        check({nm, "_result"}, res, exp_res);
        check({nm, "_latency"}, 32'(lat), exp_start ? 32'(div_lat + 1) : 32'd1);
        check({nm, "_starts"}, 32'(n_start - st0), 32'(exp_start));
        check({nm, "_pulses"}, 32'(n_rv - rv0), 32'd1);
        check({nm, "_stall"}, 32'(stall_ok), 32'd1);
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a, b, res;
        logic        start;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int st0, rv0, d0, k;
        logic [2:0]  f3;
        logic [31:0] a, b;
        logic        es;

        vecs[0]  = '{3'd5, 32'd100,        32'd7,          32'd14,         1'b1};
        vecs[1]  = '{3'd7, 32'd100,        32'd7,          32'd2,          1'b0};
        vecs[2]  = '{3'd4, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  1'b1};
        vecs[3]  = '{3'd6, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  1'b0};
        vecs[4]  = '{3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b0};
        vecs[5]  = '{3'd6, 32'd5,          32'd0,          32'd5,          1'b0};
        vecs[6]  = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0};
        vecs[7]  = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0};
        vecs[8]  = '{3'd5, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b1};
        vecs[9]  = '{3'd4, 32'd100,        32'd7,          32'd14,         1'b1};
        vecs[10] = '{3'd7, 32'd100,        32'd7,          32'd2,          1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_result_valid", 32'(result_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_dv_start", 32'(dv_start), 32'd0);
        check("rst_dv_num", dv_numerator, 32'd0);
        check("rst_dv_den", dv_denominator, 32'd0);
        check("rst_dv_sign", 32'(dv_sign), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vector table
        for (int i = 0; i < 11; i++) begin
            div_lat = 2 + (i % 4);
            void'(ref_start(vecs[i].f3, vecs[i].a, vecs[i].b));
            do_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].start);
        end

        // Non-divide op: ignored
        st0 = n_start; rv0 = n_rv;
        req_valid = 1'b1; funct3 = 3'd1; rs1 = 32'd50; rs2 = 32'd3;
        @(negedge clk);
        check("nondiv_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("nondiv_quiet", 32'(n_start - st0 + n_rv - rv0), 32'd0);
        @(posedge clk); #1;

        // Flush in IDLE: not accepted
        st0 = n_start; rv0 = n_rv;
        req_valid = 1'b1; funct3 = 3'd5; rs1 = 32'd1234; rs2 = 32'd5; flush = 1'b1;
        @(negedge clk);
        check("idle_flush_stall", 32'(stall), 32'd0);
        check("idle_flush_start", 32'(dv_start), 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("idle_flush_quiet", 32'(n_start - st0 + n_rv - rv0), 32'd0);
        @(posedge clk); #1;

        // Flush in RESP: result suppressed
        rv0 = n_rv;
        req_valid = 1'b1; funct3 = 3'd5; rs1 = 32'd5; rs2 = 32'd0;
        @(negedge clk);
        check("resp_flush_accept_stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        check("resp_flush_valid", 32'(result_valid), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check("resp_flush_pulses", 32'(n_rv - rv0), 32'd0);
        @(posedge clk); #1;

        // Flush in WAIT, then DRAIN until dv_done, then fresh divide
        div_lat = 6; st0 = n_start; rv0 = n_rv; d0 = n_done;
        req_valid = 1'b1; funct3 = 3'd5; rs1 = 32'd9; rs2 = 32'd2;
        @(negedge clk);
        check("wflush_start", 32'(dv_start), 32'd1);
        repeat (3) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(negedge clk);
        check("wflush_stall", 32'(stall), 32'd0);
        check("wflush_valid", 32'(result_valid), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("drain_stall", 32'(stall), 32'd0);
        check("drain_start", 32'(dv_start), 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        k = 0;
        while (n_done == d0 && k < 20) begin @(negedge clk); k++; end
        check("drain_done_seen", 32'(n_done - d0), 32'd1);
        @(posedge clk); #1;
        check("drain_no_result", 32'(n_rv - rv0), 32'd0);
        check("drain_one_start", 32'(n_start - st0), 32'd1);
        m_valid = 1'b0;
        div_lat = 3;
        void'(ref_start(3'd5, 32'd9, 32'd2));
        do_op("after_drain", 3'd5, 32'd9, 32'd2, 32'd4, 1'b1);

        // Reset while in WAIT
        div_lat = 6; rv0 = n_rv;
        req_valid = 1'b1; funct3 = 3'd5; rs1 = 32'd77; rs2 = 32'd3;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("wrst_valid", 32'(result_valid), 32'd0);
        check("wrst_result", result, 32'd0);
        check("wrst_start", 32'(dv_start), 32'd0);
        check("wrst_num", dv_numerator, 32'd0);
        check("wrst_den", dv_denominator, 32'd0);
        check("wrst_sign", 32'(dv_sign), 32'd0);
        check("wrst_stall", 32'(stall), 32'd0);
        repeat (8) begin @(posedge clk); #1; end
        check("wrst_stale_done", 32'(n_rv - rv0), 32'd0);
        m_valid = 1'b0;
        div_lat = 2;
        void'(ref_start(3'd5, 32'd8, 32'd2));
        do_op("after_rst", 3'd5, 32'd8, 32'd2, 32'd4, 1'b1);

        // Randomized ops against the reference model
        a = 32'd1; b = 32'd1;
        for (int i = 0; i < 60; i++) begin
            k  = int'($urandom_range(0, 9));
            f3 = 3'(4 + $urandom_range(0, 3));
            if (k < 3) begin
                // reuse previous operands to exercise cache hits
            end else if (k == 3) begin
                a = $urandom; b = 32'd0;
            end else if (k == 4) begin
                a = 32'h8000_0000; b = 32'hFFFF_FFFF;
            end else if (k < 7) begin
                a = 32'($urandom_range(0, 500)) - 32'd250;
                b = 32'($urandom_range(1, 20));
            end else begin
                a = $urandom; b = $urandom;
            end
            div_lat = int'($urandom_range(1, 5));
            es = ref_start(f3, a, b);
            do_op($sformatf("rand%0d", i), f3, a, b, ref_result(f3, a, b), es);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
